// File: rtl/ser_pkg.sv
// Shared types and link-format constants for the serial transmit scheduler.
// A frame is: start bit, destination, length, payload (MSB first), stop bit.
package ser_pkg;

  localparam int DST_W   = 2;
  localparam int LEN_W   = 4;
  localparam int HDR_W   = DST_W + LEN_W;
  localparam int MAX_LEN = (2 ** LEN_W) - 1;

  localparam logic IDLE_LINE = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    HDR,
    DATA,
    STOP,
    GAP
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_i[IDX_W'((int'(ptr_i) + i) % N_REQ)]) begin
        found = 1'b1;
        grant_o[IDX_W'((int'(ptr_i) + i) % N_REQ)] = 1'b1;
        idx_o = IDX_W'((int'(ptr_i) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/ser_tx_sched.sv
// Shares one serial line among N_REQ requesters in round-robin order, framing
// each granted request as start / {dst,len} / payload / stop, then an idle gap.
module ser_tx_sched
  import ser_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int IDLE_GAP = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [DST_W*N_REQ-1:0]   dst_i,
  input  logic [LEN_W*N_REQ-1:0]   len_i,
  input  logic [MAX_LEN*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [N_REQ-1:0]         done_o,
  output logic                     busy_o,
  output logic                     ser_out_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic [IDX_W-1:0]   owner_q;
  logic [HDR_W-1:0]   hdr_q;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] data_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_arb (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .grant_o(arb_gnt),
    .idx_o  (arb_idx)
  );

  assign ptr_d = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;

  // cnt_q is reused: header bits left, then payload bits left, then gap cycles left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      hdr_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      gnt_o     <= '0;
      done_o    <= '0;
      busy_o    <= 1'b0;
      ser_out_o <= IDLE_LINE;
    end else begin
      gnt_o  <= '0;
      done_o <= '0;
      case (state_q)
        IDLE: begin
          ser_out_o <= IDLE_LINE;
          busy_o    <= 1'b0;
          if (|req_i) begin
            gnt_o   <= arb_gnt;
            owner_q <= arb_idx;
            ptr_q   <= ptr_d;
            hdr_q   <= {dst_i[arb_idx*DST_W +: DST_W], len_i[arb_idx*LEN_W +: LEN_W]};
            len_q   <= len_i[arb_idx*LEN_W +: LEN_W];
            data_q  <= data_i[arb_idx*MAX_LEN +: MAX_LEN];
            busy_o  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          ser_out_o <= START_BIT;
          cnt_q     <= LEN_W'(HDR_W);
          state_q   <= HDR;
        end
        HDR: begin
          ser_out_o <= hdr_q[HDR_W-1];
          hdr_q     <= {hdr_q[HDR_W-2:0], 1'b0};
          cnt_q     <= cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            cnt_q   <= len_q;
            state_q <= (len_q != '0) ? DATA : STOP;
          end
        end
        DATA: begin
          ser_out_o <= data_q[cnt_q - 1'b1];
          cnt_q     <= cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          ser_out_o       <= IDLE_LINE;
          done_o[owner_q] <= 1'b1;
          cnt_q           <= LEN_W'(IDLE_GAP);
          state_q         <= GAP;
        end
        GAP: begin
          ser_out_o <= IDLE_LINE;
          cnt_q     <= cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_tx_sched.sv
// Directed and random checks of ser_tx_sched against a frame-level model that
// expands each grant into the expected per-cycle line/done/busy sequence.
module tb_ser_tx_sched;

  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int DW  = 2;
  localparam int LW  = 4;
  localparam int PW  = 15;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [DW*N-1:0] dst;
  logic [LW*N-1:0] len;
  logic [PW*N-1:0] data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            busy;
  logic            serOut;

  ser_tx_sched #(
    .N_REQ   (N),
    .IDLE_GAP(GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .dst_i    (dst),
    .len_i    (len),
    .data_i   (data),
    .gnt_o    (gnt),
    .done_o   (done),
    .busy_o   (busy),
    .ser_out_o(serOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ser;
    logic [N-1:0] done;
    logic         busy;
  } rec_t;

  rec_t        expQ[$];
  int          mptr;
  int          lastGranted;
  int          cycle;
  int          compared;
  int          mismatched;
  logic [N-1:0] dutGnt[$];
  int          dutCyc[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // The whole frame of requester k as the line should show it, one entry per cycle.
  task automatic buildFrame(input int k);
    rec_t r;
    int   l;
    l = int'(len[k*LW +: LW]);
    r.done = '0;
    r.busy = 1'b1;
    r.ser = 1'b0; expQ.push_back(r);
    for (int b = DW - 1; b >= 0; b--) begin r.ser = dst[k*DW + b]; expQ.push_back(r); end
    for (int b = LW - 1; b >= 0; b--) begin r.ser = len[k*LW + b]; expQ.push_back(r); end
    for (int b = l - 1; b >= 0; b--) begin r.ser = data[k*PW + b]; expQ.push_back(r); end
    r.ser = 1'b1; r.done = N'(1) << k; expQ.push_back(r);
    r.done = '0;
    for (int g = 0; g < GAP; g++) expQ.push_back(r);
  endtask

  task automatic applyStimulus(input int n);
    for (int s = 0; s < n; s++) begin
      int           k;
      bit           granted;
      rec_t         r;
      logic [N-1:0] eg;
      logic [N-1:0] ed;
      logic         es;
      logic         eb;
      granted = 1'b0;
      k = 0;
      if (rst_n && expQ.size() == 0 && req != '0) begin
        for (int i = 0; i < N; i++) begin
          int c;
          c = (mptr + i) % N;
          if (!granted && req[c]) begin
            granted = 1'b1;
            k = c;
          end
        end
        buildFrame(k);
        mptr = (k + 1) % N;
      end
      @(posedge clk);
      #1;
      cycle++;
      if (granted) begin
        lastGranted = k;
        eg = N'(1) << k; es = 1'b1; eb = 1'b1; ed = '0;
      end else begin
        lastGranted = -1;
        eg = '0;
        if (expQ.size() > 0) begin
          r = expQ.pop_front();
          es = r.ser; eb = r.busy; ed = r.done;
        end else begin
          es = 1'b1; eb = 1'b0; ed = '0;
        end
      end
      if (gnt != '0) begin
        dutGnt.push_back(gnt);
        dutCyc.push_back(cycle);
      end
      checkOutput("serOut", 32'(serOut), 32'(es));
      checkOutput("gnt", 32'(gnt), 32'(eg));
      checkOutput("done", 32'(done), 32'(ed));
      checkOutput("busy", 32'(busy), 32'(eb));
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    expQ.delete();
    mptr = 0;
    applyStimulus(2);
    rst_n = 1'b1;
  endtask

  task automatic randomFields(input int i);
    dst[i*DW +: DW]  = DW'($urandom);
    len[i*LW +: LW]  = LW'($urandom_range(0, 15));
    data[i*PW +: PW] = PW'($urandom);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [11:0] bitsA;
    logic [7:0]  bitsB;
    int          doneAt;
    int          lows;
    int          expG[5];

    compared = 0; mismatched = 0; cycle = 0; mptr = 0; lastGranted = -1;
    req = '0; dst = '0; len = '0; data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstSer", 32'(serOut), 32'(1));
    checkOutput("rstGnt", 32'(gnt), 32'(0));
    checkOutput("rstDone", 32'(done), 32'(0));
    checkOutput("rstBusy", 32'(busy), 32'(0));
    doReset();
    applyStimulus(2);

    // Requester 0: dst=10, len=4, data=1011
    $display("[TB] single frame, requester 0");
    dst[0 +: DW] = 2'b10; len[0 +: LW] = 4'd4; data[0 +: PW] = 15'b1011;
    req = 4'b0001;
    applyStimulus(1);
    checkOutput("gntA", 32'(gnt), 32'(4'b0001));
    req = '0;
    doneAt = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1);
      bitsA[11-i] = serOut;
      if (done[0]) doneAt = i + 1;
    end
    checkOutput("frameA", 32'(bitsA), 32'(12'b0100_1001_0111));
    checkOutput("doneAtA", 32'(doneAt), 32'(12));
    applyStimulus(5);

    // Requester 1: zero-length payload
    $display("[TB] zero-length frame, requester 1");
    dst[DW +: DW] = 2'b01; len[LW +: LW] = 4'd0; data[PW +: PW] = PW'($urandom);
    req = 4'b0010;
    applyStimulus(1);
    req = '0;
    doneAt = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1);
      bitsB[7-i] = serOut;
      if (done[1]) doneAt = i + 1;
    end
    checkOutput("frameB", 32'(bitsB), 32'(8'b0010_0001));
    checkOutput("doneAtB", 32'(doneAt), 32'(8));
    applyStimulus(4);

    // Reset in the third header cycle of a frame
    $display("[TB] reset mid-frame");
    randomFields(2);
    len[2*LW +: LW] = LW'($urandom_range(1, 15));
    req = 4'b0100;
    applyStimulus(1);
    req = '0;
    applyStimulus(4);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstSer", 32'(serOut), 32'(1));
    checkOutput("midRstBusy", 32'(busy), 32'(0));
    checkOutput("midRstGnt", 32'(gnt), 32'(0));
    expQ.delete();
    mptr = 0;
    applyStimulus(2);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1);
      if (serOut !== 1'b1) lows++;
    end
    checkOutput("idleAfterRst", 32'(lows), 32'(0));

    // Fields changed after grant must not affect the frame in flight
    $display("[TB] inputs changed after grant");
    randomFields(2);
    len[2*LW +: LW] = 4'd5;
    req = 4'b0100;
    applyStimulus(1);
    checkOutput("gntC", 32'(gnt), 32'(4'b0100));
    req = '0;
    len[2*LW +: LW] = 4'd15;
    data[2*PW +: PW] = 15'h7fff;
    applyStimulus(20);

    // All four requesting, len=3: round-robin order and 14-cycle spacing
    $display("[TB] all requesters, round robin");
    doReset();
    for (int i = 0; i < N; i++) begin
      randomFields(i);
      len[i*LW +: LW] = 4'd3;
    end
    dutGnt.delete(); dutCyc.delete();
    req = 4'b1111;
    applyStimulus(57);
    req = '0;
    applyStimulus(20);
    expG[0] = 1; expG[1] = 2; expG[2] = 4; expG[3] = 8; expG[4] = 1;
    checkOutput("rrCount", 32'(dutGnt.size()), 32'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < dutGnt.size()) begin
        checkOutput("rrOrder", 32'(dutGnt[i]), 32'(expG[i]));
        if (i > 0) checkOutput("rrSpacing", 32'(dutCyc[i] - dutCyc[i-1]), 32'(3 + GAP + 9));
      end
    end

    // Pointer is now 1: req 0 and 3 together -> 3 first; a dropped req 1 is skipped
    $display("[TB] wrap priority and dropped request");
    dutGnt.delete(); dutCyc.delete();
    req = 4'b1001;
    applyStimulus(1);
    req[3] = 1'b0;
    req[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1);
      if (i == 3) req[1] = 1'b0;
      if (lastGranted >= 0) req[lastGranted] = 1'b0;
    end
    checkOutput("wrapCount", 32'(dutGnt.size()), 32'(2));
    if (dutGnt.size() >= 2) begin
      checkOutput("wrapFirst", 32'(dutGnt[0]), 32'(4'b1000));
      checkOutput("wrapSecond", 32'(dutGnt[1]), 32'(4'b0001));
    end

    // Random traffic obeying the hold-until-grant rule
    $display("[TB] random traffic");
    for (int s = 0; s < 500; s++) begin
      applyStimulus(1);
      for (int i = 0; i < N; i++) begin
        if (lastGranted == i) begin
          randomFields(i);
          req[i] = 1'($urandom_range(0, 1));
        end else if (req[i]) begin
          if ($urandom_range(0, 63) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          randomFields(i);
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    applyStimulus(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
